uart_cmd_rx: RTL
================

// Module: uart_cmd_rx
// PURPOSE
//  Receive end of the BLE command link: 8N1 UART receiver plus power-up authorisation FSM.
//  Sits in Segway top behind the RX pin, driven by the host/BLE transmitter.
//  Decodes 'g' (8'h67) and 's' (8'h73).
//  Produces pwr_up for the balance controller and exposes raw bytes via rdy/clr_rdy.
// PARAMETERS
//  BAUD_DIV  2604  clk cycles per bit (50MHz / 19200 baud); must be >= 16
//  CMD_GO    8'h67 byte that requests power-up
//  CMD_STOP  8'h73 byte that requests power-down
// PORTS
//  clk        in   1  system clock, single clock domain
//  rst        in   1  reset; one clock; reset is synchronous and active-high
//  RX         in   1  asynchronous serial input, idle high
//  clr_rdy    in   1  consumer acknowledge; clears rdy
//  rider_off  in   1  load cells report no rider
//  rx_data    out  8  last correctly framed byte
//  rdy        out  1  rx_data holds an unread byte
//  frm_err    out  1  sticky: last frame had a bad stop (or parity) bit
//  pwr_up     out  1  authorisation to drive motors
// BEHAVIOUR
//  Reset values:
//   - rx_data=0, rdy=0, frm_err=0, pwr_up=0.
//   - RX sync flops=1; receiver in IDLE; auth FSM in OFF.
//   - rst mid-frame aborts the frame; no byte is delivered.
//  Input synchronisation: RX passes through 2 flops (rx_s). Edge detect uses rx_s and its delayed copy.
//  Receiver FSM IDLE -> START -> DATA -> [PAR] -> STOP -> IDLE:
//   - IDLE: on rx_s falling edge, load baud cnt = BAUD_DIV/2, clear rdy and frm_err, go to START.
//   - START: at cnt==0 sample rx_s.
//       rx_s=1: false start, back to IDLE with no flags.
//       rx_s=0: reload cnt = BAUD_DIV-1, go to DATA.
//   - DATA: sample 8 bits at cnt==0, each BAUD_DIV apart. Shift right, LSB first. 3-bit bit counter.
//   - STOP: at cnt==0 sample stop bit.
//       stop=1 (and parity ok): rx_data<=shift reg, rdy<=1 next clk.
//       otherwise: frm_err<=1, rdy and rx_data unchanged.
//       Either way return to IDLE the same cycle, so a back-to-back start bit is caught.
//  Latency: rdy rises 2 sync + (9.5 or 10.5 with parity)*BAUD_DIV +1 clks after RX start falling edge.
//  Handshake:
//   - rdy held until clr_rdy=1 or the next start bit is detected.
//   - clr_rdy in the same clk as frame completion: set wins, rdy=1.
//   - Unread byte overwritten by a new good frame; no overrun flag.
//  Command decode: one-clk internal strobe on each good frame. Bytes other than CMD_GO/CMD_STOP are ignored by the FSM but still delivered.
//  Auth FSM (pwr_up=1 in PWR1 and PWR2, registered):
//   - OFF:  CMD_GO -> PWR1.
//   - PWR1: CMD_STOP & rider_off -> OFF; CMD_STOP & !rider_off -> PWR2.
//   - PWR2: CMD_GO -> PWR1; rider_off -> OFF.
//       CMD_GO and rider_off in the same clk -> PWR1 (go wins).
//   - pwr_up changes the clk after the strobe.
//  Framing-errored bytes never reach the FSM.
// CONFIGURATION
//  UART_PARITY_EN defined:
//   - PAR state inserted after DATA; expects even parity over the 8 data bits.
//   - Mismatch sets frm_err and suppresses rdy and strobe, like a bad stop bit.
//  UART_PARITY_EN undefined: 8N1 only; PAR state and parity logic absent.
// TESTING
//  1 Reset then idle RX=1 for 10000 clks -> rdy=0, frm_err=0, pwr_up=0, rx_data=0.
//  2 Send 8'hA5 8N1 at BAUD_DIV=2604 -> rx_data=8'hA5 and rdy=1 within 27400 clks.
//    Then clr_rdy pulse -> rdy=0 next clk.
//  3 Stop bit forced 0 on 8'h3C -> frm_err=1, rdy=0, rx_data holds previous value, pwr_up unchanged.
//  4 rider_off=0: send 8'h67 -> pwr_up=1. Send 8'h73 -> pwr_up stays 1.
//    Raise rider_off -> pwr_up=0 next clk.
//  5 Two frames back-to-back (stop bit then start bit immediately): 8'h67, 8'h73 with rider_off=1.
//    Both bytes received; pwr_up 0->1->0.
//    Also: 1-clk RX glitch low -> no frame, no frm_err.
//  6 rst asserted mid-DATA of 8'h67 -> no rdy and pwr_up=0.
//    Next full 8'h67 received correctly.
//    With UART_PARITY_EN: 8'h67 with odd parity -> frm_err=1, pwr_up=0.

Source files
------------

// File: rtl/uart_cmd_rx.sv
// ============================================================================
//  Module   : uart_cmd_rx
//  Purpose  : 8N1 UART receiver with a 'g'/'s' power-up authorisation FSM.
//             Optional even parity when UART_PARITY_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_cmd_rx #(
  parameter int          BAUD_DIV = 2604,
  parameter logic [7:0]  CMD_GO   = 8'h67,
  parameter logic [7:0]  CMD_STOP = 8'h73
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       clr_rdy,
  input  logic       rider_off,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err,
  output logic       pwr_up
);

  localparam int          CW   = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2);
  localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
`ifdef UART_PARITY_EN
    RX_PAR   = 3'd3,
`endif
    RX_STOP  = 3'd4
  } rx_state_t;

  typedef enum logic [1:0] {
    AUTH_OFF  = 2'd0,
    AUTH_PWR1 = 2'd1,
    AUTH_PWR2 = 2'd2
  } auth_state_t;

  rx_state_t   rx_state;
  auth_state_t auth_state;

  logic          rx_meta;
  logic          rx_s;
  logic          rx_s_d;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic          cmd_stb;
  logic          start_edge;
  logic          par_ok;

  assign start_edge = rx_s_d & ~rx_s;

`ifdef UART_PARITY_EN
  logic par_bit;
  assign par_ok = ~(^shift_reg ^ par_bit);
`else
  assign par_ok = 1'b1;
`endif

  // Two-flop synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_d  <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_s    <= rx_meta;
      rx_s_d  <= rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state  <= RX_IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      rx_data   <= '0;
      rdy       <= 1'b0;
      frm_err   <= 1'b0;
      cmd_stb   <= 1'b0;
`ifdef UART_PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      cmd_stb <= 1'b0;
      // Later assignments in the STOP branch override this, so a frame
      // completing in the same cycle as clr_rdy leaves rdy set.
      if (clr_rdy) rdy <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (start_edge) begin
            baud_cnt <= HALF;
            rdy      <= 1'b0;
            frm_err  <= 1'b0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (baud_cnt != '0) begin
            baud_cnt <= baud_cnt - 1'b1;
          end else if (rx_s) begin
            rx_state <= RX_IDLE;
          end else begin
            baud_cnt <= FULL;
            bit_cnt  <= '0;
            rx_state <= RX_DATA;
          end
        end
        RX_DATA: begin
          if (baud_cnt != '0) begin
            baud_cnt <= baud_cnt - 1'b1;
          end else begin
            shift_reg <= {rx_s, shift_reg[7:1]};
            baud_cnt  <= FULL;
            bit_cnt   <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
`ifdef UART_PARITY_EN
              rx_state <= RX_PAR;
`else
              rx_state <= RX_STOP;
`endif
            end
          end
        end
`ifdef UART_PARITY_EN
        RX_PAR: begin
          if (baud_cnt != '0) begin
            baud_cnt <= baud_cnt - 1'b1;
          end else begin
            par_bit  <= rx_s;
            baud_cnt <= FULL;
            rx_state <= RX_STOP;
          end
        end
`endif
        RX_STOP: begin
          if (baud_cnt != '0) begin
            baud_cnt <= baud_cnt - 1'b1;
          end else begin
            if (rx_s && par_ok) begin
              rx_data <= shift_reg;
              rdy     <= 1'b1;
              cmd_stb <= 1'b1;
            end else begin
              frm_err <= 1'b1;
            end
            // Back to IDLE at mid-stop so an immediate next start bit is seen
            rx_state <= RX_IDLE;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // cmd_stb and rx_data update on the same edge, so rx_data is the new byte
  always_ff @(posedge clk) begin
    if (rst) begin
      auth_state <= AUTH_OFF;
      pwr_up     <= 1'b0;
    end else begin
      case (auth_state)
        AUTH_OFF: begin
          if (cmd_stb && rx_data == CMD_GO) begin
            auth_state <= AUTH_PWR1;
            pwr_up     <= 1'b1;
          end
        end
        AUTH_PWR1: begin
          if (cmd_stb && rx_data == CMD_STOP) begin
            if (rider_off) begin
              auth_state <= AUTH_OFF;
              pwr_up     <= 1'b0;
            end else begin
              auth_state <= AUTH_PWR2;
            end
          end
        end
        AUTH_PWR2: begin
          if (cmd_stb && rx_data == CMD_GO) begin
            auth_state <= AUTH_PWR1;
          end else if (rider_off) begin
            auth_state <= AUTH_OFF;
            pwr_up     <= 1'b0;
          end
        end
        default: begin
          auth_state <= AUTH_OFF;
          pwr_up     <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
